// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single SRAM-like bus with one outstanding transaction.
// Round-robin on conflict; request fields are latched at grant so requesters may change them freely afterwards.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ok,
  input  logic              d_en,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_d;
  logic              completing;

  // D wins when alone, or on conflict when I was the previous winner
  assign grant_d = d_en & (~i_en | (last_grant == PORT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= PORT_I;
      last_grant <= PORT_I;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_en | d_en) begin
            state      <= ADDR;
            owner      <= grant_d;
            last_grant <= grant_d;
            if (grant_d) begin
              wr_q    <= d_wr;
              size_q  <= d_size;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              wr_q    <= 1'b0;
              size_q  <= 2'd2;
              addr_q  <= i_addr;
              wdata_q <= '0;
            end
          end
        end
        ADDR: if (bus_addr_ok) state <= DATA;
        DATA: if (bus_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_req   = (state == ADDR);
  assign bus_wr    = bus_req & wr_q;
  assign bus_size  = bus_req ? size_q  : 2'd0;
  assign bus_addr  = bus_req ? addr_q  : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;

  assign completing = (state == DATA) & bus_data_ok;
  assign i_ok       = completing & (owner == PORT_I);
  assign d_ok       = completing & (owner == PORT_D);
  assign i_rdata    = i_ok ? bus_rdata : '0;
  assign d_rdata    = d_ok ? bus_rdata : '0;

  assign stallreq = (i_en & ~i_ok) | (d_en & ~d_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, every cycle checked against a transaction model.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en, d_en, d_wr, i_ok, d_ok;
  logic [AW-1:0] i_addr, d_addr, bus_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, bus_wdata, bus_rdata;
  logic [1:0]    d_size, bus_size;
  logic          bus_req, bus_wr, bus_addr_ok, bus_data_ok, stallreq;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_ok(i_ok),
    .d_en(d_en), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ok(d_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Transaction-level reference: at most one pending transfer, described by its owner and captured fields.
  logic          m_pending, m_addr_done, m_owner_d, m_last_d;
  logic          m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            ok_log[$];  // 1 = D completed, 0 = I completed

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic          e_req, e_iok, e_dok, pick_d;
    @(negedge clk);
    e_req = m_pending && !m_addr_done;
    e_iok = m_pending && m_addr_done && bus_data_ok && !m_owner_d;
    e_dok = m_pending && m_addr_done && bus_data_ok && m_owner_d;
    chk("bus_req",   {63'd0, bus_req},  {63'd0, e_req});
    chk("bus_wr",    {63'd0, bus_wr},   {63'd0, e_req && m_wr});
    chk("bus_size",  {62'd0, bus_size}, {62'd0, (e_req ? m_size : 2'd0)});
    chk("bus_addr",  {32'd0, bus_addr}, {32'd0, (e_req ? m_addr : 32'd0)});
    chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, (e_req ? m_wdata : 32'd0)});
    chk("i_ok",      {63'd0, i_ok},     {63'd0, e_iok});
    chk("d_ok",      {63'd0, d_ok},     {63'd0, e_dok});
    chk("i_rdata",   {32'd0, i_rdata},  {32'd0, (e_iok ? bus_rdata : 32'd0)});
    chk("d_rdata",   {32'd0, d_rdata},  {32'd0, (e_dok ? bus_rdata : 32'd0)});
    chk("stallreq",  {63'd0, stallreq}, {63'd0, (i_en && !e_iok) || (d_en && !e_dok)});
    if (i_ok) ok_log.push_back(0);
    if (d_ok) ok_log.push_back(1);
    @(posedge clk);
    if (rst) begin
      m_pending = 1'b0; m_addr_done = 1'b0; m_last_d = 1'b0;
    end else if (!m_pending) begin
      if (i_en || d_en) begin
        pick_d = d_en && !(i_en && m_last_d);
        m_pending = 1'b1; m_addr_done = 1'b0; m_owner_d = pick_d; m_last_d = pick_d;
        m_wr    = pick_d ? d_wr    : 1'b0;
        m_size  = pick_d ? d_size  : 2'd2;
        m_addr  = pick_d ? d_addr  : i_addr;
        m_wdata = pick_d ? d_wdata : 32'd0;
      end
    end else if (!m_addr_done) begin
      if (bus_addr_ok) m_addr_done = 1'b1;
    end else if (bus_data_ok) begin
      m_pending = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [AW-1:0] saved_addr;
    m_pending = 0; m_addr_done = 0; m_owner_d = 0; m_last_d = 0;
    m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    rst = 1; i_en = 0; i_addr = 0; d_en = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    tick(); tick();
    rst = 0; #1;
    chk("reset_bus_req", {63'd0, bus_req}, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    tick();

    // Single fetch, zero-wait slave
    i_en = 1; i_addr = 32'hBFC00000; tick();
    bus_addr_ok = 1; #1;
    chk("fetch_req_n1", {63'd0, bus_req}, 64'd1);
    chk("fetch_size", {62'd0, bus_size}, 64'd2);
    chk("fetch_addr", {32'd0, bus_addr}, 64'hBFC00000);
    tick();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D0000; #1;
    chk("fetch_ok_n2", {63'd0, i_ok}, 64'd1);
    chk("fetch_rdata", {32'd0, i_rdata}, 64'h3C1D0000);
    chk("fetch_stall_n2", {63'd0, stallreq}, 64'd0);
    chk("fetch_req_n2", {63'd0, bus_req}, 64'd0);
    tick();
    i_en = 0; bus_data_ok = 0; tick();

    // Byte store
    d_en = 1; d_wr = 1; d_size = 0; d_addr = 32'h80000003; d_wdata = 32'hAB000000; tick();
    bus_addr_ok = 1; #1;
    chk("store_addr", {32'd0, bus_addr}, 64'h80000003);
    chk("store_wdata", {32'd0, bus_wdata}, 64'hAB000000);
    chk("store_wr", {63'd0, bus_wr}, 64'd1);
    chk("store_size", {62'd0, bus_size}, 64'd0);
    tick();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = $urandom; #1;
    chk("store_d_ok", {63'd0, d_ok}, 64'd1);
    chk("store_i_ok", {63'd0, i_ok}, 64'd0);
    tick();
    d_en = 0; d_wr = 0; bus_data_ok = 0; tick();

    // Contention out of reset with a zero-wait slave: expect D, I, D, I
    rst = 1; tick(); rst = 0;
    i_en = 1; d_en = 1; i_addr = 32'h1000; d_addr = 32'h2000; d_size = 2;
    bus_addr_ok = 1; bus_data_ok = 1;
    ok_log.delete();
    repeat (12) tick();
    chk("contend_count", ok_log.size(), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("contend_order", (ok_log.size() > k) ? ok_log[k] : 64'hF, (k % 2 == 0) ? 64'd1 : 64'd0);
    i_en = 0; d_en = 0; bus_addr_ok = 0; bus_data_ok = 0; tick();

    // Slave wait states, stray data_ok in ADDR, mid-transaction field change and drop of d_en
    d_en = 1; d_wr = 0; d_size = 2; d_addr = 32'hA000_0040; d_wdata = 32'h55AA55AA; tick();
    saved_addr = 32'hA000_0040;
    d_addr = 32'h1234; bus_data_ok = 1; tick();
    #1; chk("mid_addr_kept", {32'd0, bus_addr}, {32'd0, saved_addr});
    bus_data_ok = 0; tick(); tick();
    bus_addr_ok = 1; tick();
    bus_addr_ok = 0; d_en = 0;
    repeat (3) tick();
    bus_data_ok = 1; bus_rdata = 32'hCAFEF00D; #1;
    chk("drop_d_ok", {63'd0, d_ok}, 64'd1);
    chk("drop_d_rdata", {32'd0, d_rdata}, 64'hCAFEF00D);
    tick();
    bus_data_ok = 0; tick();
    chk("drop_idle", {63'd0, bus_req}, 64'd0);

    // Reset while in DATA, then a conflict must go to D
    i_en = 1; tick();
    bus_addr_ok = 1; tick();
    bus_addr_ok = 0; rst = 1; tick();
    rst = 0; i_en = 0; bus_data_ok = 1; #1;
    chk("rst_no_ok", {62'd0, i_ok, d_ok}, 64'd0);
    chk("rst_no_req", {63'd0, bus_req}, 64'd0);
    tick();
    bus_data_ok = 0; tick();
    i_en = 1; d_en = 1; bus_addr_ok = 1; bus_data_ok = 1; ok_log.delete();
    repeat (3) tick();
    chk("rst_first_d", (ok_log.size() > 0) ? ok_log[0] : 64'hF, 64'd1);
    i_en = 0; d_en = 0; bus_addr_ok = 0; bus_data_ok = 0; tick();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      i_en        = ($urandom_range(0, 9) < 6);
      d_en        = ($urandom_range(0, 9) < 5);
      i_addr      = $urandom;
      d_wr        = $urandom_range(0, 1);
      d_size      = 2'($urandom_range(0, 2));
      d_addr      = $urandom;
      d_wdata     = $urandom;
      bus_addr_ok = $urandom_range(0, 1);
      bus_data_ok = $urandom_range(0, 1);
      bus_rdata   = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
